sprite_frame_ctrl: RTL and testbench

Control FSM that sequences one animated sprite through draw → frame wait → erase → position update, driving the enable inputs of the sprite-drawing datapath and the VGA adapter's plot strobe. It sits directly upstream of the sprite datapath, which holds position/colour and emits per-pixel x/y/colour. The pixel count is derived from the sprite width/height, and motion is paced by a 60 Hz rate divider.

---
 rtl/sprite_pkg.sv | 29 ++
 rtl/sprite_frame_ctrl_if.sv | 29 ++
 rtl/sprite_frame_ctrl_rate_divider.sv | 49 ++++
 rtl/sprite_frame_ctrl.sv | 116 +++++++++++
 tb/tb_sprite_frame_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite frame controller.
//   state_e         - controller FSM states
//   DELAY_MAX_60HZ  - clock cycles per 60 Hz tick at 50 MHz
//   PIX_CNT_W       - pixel counter width (holds up to 32768 pixels)
//   pix_last()      - index of the last pixel for a given width-1/height-1
package sprite_pkg;

  localparam int unsigned DELAY_MAX_60HZ = 833333;
  localparam int unsigned PIX_CNT_W      = 16;
  localparam int unsigned ProdW          = PIX_CNT_W + 1;

  typedef enum logic [2:0] {
    StIdle,
    StDrawPrep,
    StDraw,
    StWait,
    StErasePrep,
    StErase,
    StUpdate
  } state_e;

  // (w+1)*(h+1)-1; computed one bit wider so 256*128 cannot wrap.
  function automatic logic [PIX_CNT_W-1:0] pix_last(input logic [7:0] w, input logic [6:0] h);
    logic [ProdW-1:0] prod;
    prod = (ProdW'(w) + ProdW'(1)) * (ProdW'(h) + ProdW'(1));
    return PIX_CNT_W'(prod - ProdW'(1));
  endfunction

endpackage

// File: rtl/sprite_frame_ctrl_if.sv
// sprite_frame_ctrl_if: control bundle between the frame controller and the
// sprite datapath / VGA adapter.
//   run, width, height                    - requests into the controller
//   enable, enable_fcounter, enable_erase,
//   enable_update, plot, busy             - strobes out of the controller
// master: controller side. slave: datapath/driver side.
interface sprite_frame_ctrl_if;

  logic       run;
  logic [7:0] width;
  logic [6:0] height;
  logic       enable;
  logic       enable_fcounter;
  logic       enable_erase;
  logic       enable_update;
  logic       plot;
  logic       busy;

  modport master (
    input  run, width, height,
    output enable, enable_fcounter, enable_erase, enable_update, plot, busy
  );

  modport slave (
    output run, width, height,
    input  enable, enable_fcounter, enable_erase, enable_update, plot, busy
  );

endinterface

// File: rtl/sprite_frame_ctrl_rate_divider.sv
// rate_divider: paces the WAIT state. Counts DELAY_MAX cycles per tick and
// FRAMES_PER_MOVE ticks per move.
//   clock, reset_n - clock and synchronous active-low reset
//   i_clear        - hold both counters at zero
//   i_en           - advance the counters
//   o_done         - one-cycle pulse on the final counted cycle
module rate_divider
  import sprite_pkg::*;
#(
  parameter int unsigned DELAY_MAX       = DELAY_MAX_60HZ,
  parameter int unsigned FRAMES_PER_MOVE = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_done
);

  localparam int unsigned DelayW = (DELAY_MAX > 1) ? $clog2(DELAY_MAX) : 1;
  localparam int unsigned FrameW = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
  localparam logic [DelayW-1:0] DelayLast = DelayW'(DELAY_MAX - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(FRAMES_PER_MOVE - 1);

  logic [DelayW-1:0] r_delay;
  logic [FrameW-1:0] r_frame;
  logic              w_delay_wrap;
  logic              w_frame_last;

  assign w_delay_wrap = (r_delay == DelayLast);
  assign w_frame_last = (r_frame == FrameLast);
  assign o_done       = i_en && w_delay_wrap && w_frame_last;

  always_ff @(posedge clock) begin
    if (!reset_n || i_clear) begin
      r_delay <= '0;
      r_frame <= '0;
    end else if (i_en) begin
      if (w_delay_wrap) begin
        r_delay <= '0;
        // Frame counter wraps too, so the next WAIT starts from zero.
        r_frame <= w_frame_last ? '0 : r_frame + FrameW'(1);
      end else begin
        r_delay <= r_delay + DelayW'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_frame_ctrl.sv
// sprite_frame_ctrl: sequences one sprite through draw, frame wait, erase and
// position update, driving the sprite datapath enables and the VGA plot strobe.
//   clock, reset_n - clock and synchronous active-low reset
//   io_bus         - control bundle (run/width/height in, strobes out)
// All outputs decode from the registered state only.
module sprite_frame_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned DELAY_MAX       = DELAY_MAX_60HZ,
  parameter int unsigned FRAMES_PER_MOVE = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  sprite_frame_ctrl_if.master io_bus
);

  state_e               r_state;
  state_e               w_state_next;
  logic [7:0]           r_w_l;
  logic [6:0]           r_h_l;
  logic [PIX_CNT_W-1:0] r_pix_cnt;
  logic [PIX_CNT_W-1:0] w_pix_last;
  logic                 w_pix_done;
  logic                 w_in_wait;
  logic                 w_wait_done;
  logic                 w_pixel_state;

  // Size is taken from the latched copy so mid-pass input changes are ignored.
  assign w_pix_last    = pix_last(r_w_l, r_h_l);
  assign w_pix_done    = (r_pix_cnt == w_pix_last);
  assign w_in_wait     = (r_state == StWait);
  assign w_pixel_state = (r_state == StDraw) || (r_state == StErase);

  rate_divider #(
    .DELAY_MAX      (DELAY_MAX),
    .FRAMES_PER_MOVE(FRAMES_PER_MOVE)
  ) u_rate_divider (
    .clock  (clock),
    .reset_n(reset_n),
    .i_clear(!w_in_wait),
    .i_en   (w_in_wait),
    .o_done (w_wait_done)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_w_l     <= '0;
      r_h_l     <= '0;
      r_pix_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StDrawPrep) begin
        r_w_l <= io_bus.width;
        r_h_l <= io_bus.height;
      end
      if (w_pixel_state && !w_pix_done) begin
        r_pix_cnt <= r_pix_cnt + PIX_CNT_W'(1);
      end else begin
        r_pix_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:      if (io_bus.run) w_state_next = StDrawPrep;
      StDrawPrep:  w_state_next = StDraw;
      StDraw:      if (w_pix_done) w_state_next = StWait;
      StWait:      if (w_wait_done) w_state_next = io_bus.run ? StErasePrep : StIdle;
      StErasePrep: w_state_next = StErase;
      StErase:     if (w_pix_done) w_state_next = StUpdate;
      StUpdate:    w_state_next = StDrawPrep;
      default:     w_state_next = StIdle;
    endcase
  end

  always_comb begin
    io_bus.enable          = 1'b0;
    io_bus.enable_fcounter = 1'b0;
    io_bus.enable_erase    = 1'b0;
    io_bus.enable_update   = 1'b0;
    io_bus.plot            = 1'b0;
    io_bus.busy            = (r_state != StIdle);
    unique case (r_state)
      StIdle:      io_bus.enable_fcounter = 1'b1;
      StDrawPrep:  io_bus.enable_fcounter = 1'b1;
      StDraw: begin
        io_bus.enable = 1'b1;
        io_bus.plot   = 1'b1;
      end
      StWait:      io_bus.enable_fcounter = 1'b1;
      // Erase colour goes black one cycle early so the datapath's registered
      // colour is already black on the first erased pixel.
      StErasePrep: begin
        io_bus.enable_erase    = 1'b1;
        io_bus.enable_fcounter = 1'b1;
      end
      StErase: begin
        io_bus.enable_erase = 1'b1;
        io_bus.enable       = 1'b1;
        io_bus.plot         = 1'b1;
      end
      StUpdate: begin
        io_bus.enable_update   = 1'b1;
        io_bus.enable_fcounter = 1'b1;
      end
      default: begin
        io_bus.enable_fcounter = 1'b1;
        io_bus.busy            = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sprite_frame_ctrl.sv
// tb_sprite_frame_ctrl: self-checking bench for sprite_frame_ctrl with
// DELAY_MAX=4, FRAMES_PER_MOVE=2. Expected behaviour is an output timeline built
// from phase lengths (prep, N draw, wait, prep, N erase, update).
module tb_sprite_frame_ctrl;

  localparam int unsigned DelayMax      = 4;
  localparam int unsigned FramesPerMove = 2;
  localparam int          WaitCycles    = DelayMax * FramesPerMove;

  // Output vector order: {busy, plot, enable_update, enable_erase, enable_fcounter, enable}
  localparam logic [5:0] VIdle   = 6'b000010;
  localparam logic [5:0] VPrep   = 6'b100010;
  localparam logic [5:0] VDraw   = 6'b110001;
  localparam logic [5:0] VWait   = 6'b100010;
  localparam logic [5:0] VErPrep = 6'b100110;
  localparam logic [5:0] VErase  = 6'b110101;
  localparam logic [5:0] VUpd    = 6'b101010;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sprite_frame_ctrl_if bus_if ();

  sprite_frame_ctrl #(
    .DELAY_MAX      (DelayMax),
    .FRAMES_PER_MOVE(FramesPerMove)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .io_bus (bus_if)
  );

  int checks   = 0;
  int failures = 0;
  logic [5:0] exp_q[$];

  typedef struct {
    int w;
    int h;
    int draw_plots;
    int erase_plots;
    int erase_hi;
    int period;
  } vec_t;

  vec_t tbl[3];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] obs();
    return {bus_if.busy, bus_if.plot, bus_if.enable_update, bus_if.enable_erase,
            bus_if.enable_fcounter, bus_if.enable};
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  // Reference timeline of one full pass with n pixels.
  task automatic push_pass(input int n);
    exp_q.push_back(VPrep);
    for (int i = 0; i < n; i++) exp_q.push_back(VDraw);
    for (int i = 0; i < WaitCycles; i++) exp_q.push_back(VWait);
    exp_q.push_back(VErPrep);
    for (int i = 0; i < n; i++) exp_q.push_back(VErase);
    exp_q.push_back(VUpd);
  endtask

  task automatic check_queue(input string name);
    logic [5:0] e;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check(name, int'(obs()), int'(e));
    end
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    bus_if.run = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("reset_idle", int'(obs()), int'(VIdle));
  endtask

  task automatic run_measure(input int w, input int h, output int lat, output int dp,
                             output int ep, output int eh, output int per, output int upd);
    bus_if.width  = 8'(w);
    bus_if.height = 7'(h);
    bus_if.run    = 1'b1;
    lat = 0; dp = 0; ep = 0; eh = 0; per = 0; upd = 0;
    for (int c = 1; c <= 2000; c++) begin
      tick();
      per++;
      if (bus_if.plot && lat == 0) lat = c;
      if (bus_if.plot && !bus_if.enable_erase) dp++;
      if (bus_if.plot && bus_if.enable_erase) ep++;
      if (bus_if.enable_erase) eh++;
      if (bus_if.enable_update) begin
        upd++;
        break;
      end
    end
  endtask

  // Two passes traced cycle by cycle; size switches to (w2,h2) at cycle chg,
  // and live inputs are scrambled once the second pass has latched.
  task automatic trace_run(input string name, input int w1, input int h1, input int w2,
                           input int h2, input int chg);
    logic [5:0] e;
    int per1;
    per1 = 2 * (w1 + 1) * (h1 + 1) + WaitCycles + 3;
    exp_q = {};
    push_pass((w1 + 1) * (h1 + 1));
    push_pass((w2 + 1) * (h2 + 1));
    bus_if.width  = 8'(w1);
    bus_if.height = 7'(h1);
    bus_if.run    = 1'b1;
    for (int c = 1; exp_q.size() > 0; c++) begin
      tick();
      e = exp_q.pop_front();
      check(name, int'(obs()), int'(e));
      if (c == chg) begin
        bus_if.width  = 8'(w2);
        bus_if.height = 7'(h2);
      end
      if (c > per1 + 1) begin
        bus_if.width  = 8'($urandom);
        bus_if.height = 7'($urandom);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, dp, ep, eh, per, upd, w1, h1, w2, h2, chg, n;

    bus_if.run    = 1'b0;
    bus_if.width  = '0;
    bus_if.height = '0;
    reset_n       = 1'b0;
    tick();
    tick();
    check("reset_state", int'(obs()), int'(VIdle));
    reset_n = 1'b1;
    tick();
    tick();
    check("idle_no_run", int'(obs()), int'(VIdle));

    // Table-driven pass measurements.
    tbl[0] = '{w: 3, h: 1, draw_plots: 8, erase_plots: 8, erase_hi: 9, period: 27};
    tbl[1] = '{w: 0, h: 0, draw_plots: 1, erase_plots: 1, erase_hi: 2, period: 13};
    tbl[2] = '{w: 1, h: 2, draw_plots: 6, erase_plots: 6, erase_hi: 7, period: 23};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      run_measure(tbl[i].w, tbl[i].h, lat, dp, ep, eh, per, upd);
      check("first_plot_latency", lat, 2);
      check("draw_plots", dp, tbl[i].draw_plots);
      check("erase_plots", ep, tbl[i].erase_plots);
      check("erase_high", eh, tbl[i].erase_hi);
      check("period", per, tbl[i].period);
      check("update_pulses", upd, 1);
      tick();
      check("after_update_prep", int'(obs()), int'(VPrep));
    end

    // Randomized two-pass traces against the timeline model.
    for (int r = 0; r < 6; r++) begin
      w1  = int'($urandom_range(0, 7));
      h1  = int'($urandom_range(0, 5));
      w2  = int'($urandom_range(0, 7));
      h2  = int'($urandom_range(0, 5));
      chg = int'($urandom_range(2, 2 * (w1 + 1) * (h1 + 1) + WaitCycles + 3));
      do_reset();
      trace_run("rand_trace", w1, h1, w2, h2, chg);
    end

    // Width 3->7 during WAIT: erase still 8 pixels, next draw 16.
    do_reset();
    trace_run("width_change_wait", 3, 1, 7, 1, 12);

    // run dropped during DRAW: finish draw and wait, then idle without erase.
    do_reset();
    bus_if.width  = 8'd2;
    bus_if.height = 7'd0;
    bus_if.run    = 1'b1;
    exp_q = {};
    exp_q.push_back(VPrep);
    for (int i = 0; i < 3; i++) exp_q.push_back(VDraw);
    for (int i = 0; i < WaitCycles; i++) exp_q.push_back(VWait);
    for (int i = 0; i < 4; i++) exp_q.push_back(VIdle);
    for (int c = 1; exp_q.size() > 0; c++) begin
      tick();
      check("run_drop", int'(obs()), int'(exp_q.pop_front()));
      if (c == 2) bus_if.run = 1'b0;
    end

    // Reset during the 4th DRAW cycle aborts, then a full pass restarts.
    do_reset();
    bus_if.width  = 8'd3;
    bus_if.height = 7'd1;
    bus_if.run    = 1'b1;
    tick();
    check("mid_reset_prep", int'(obs()), int'(VPrep));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_reset_draw", int'(obs()), int'(VDraw));
    end
    reset_n = 1'b0;
    tick();
    check("mid_reset_idle", int'(obs()), int'(VIdle));
    reset_n = 1'b1;
    exp_q = {};
    push_pass(8);
    check_queue("mid_reset_restart");

    // Largest sprite: 32768 consecutive plots then WAIT.
    do_reset();
    bus_if.width  = 8'd255;
    bus_if.height = 7'd127;
    bus_if.run    = 1'b1;
    tick();
    check("big_prep", int'(obs()), int'(VPrep));
    n = 0;
    for (int c = 0; c < 40000; c++) begin
      tick();
      if (obs() == VDraw) n++;
      else break;
    end
    check("big_draw_plots", n, 32768);
    check("big_wait", int'(obs()), int'(VWait));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
